// File: rtl/spi_pkg.sv
// Shared types and constants for the SPI slave endpoint.
// State encoding is one-hot; bus mode is packed as {CKP, CPH}.
package spi_pkg;

  localparam int unsigned SPI_WIDTH = 16;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'b001,
    ST_ACTIVE = 3'b010,
    ST_DONE   = 3'b100
  } spi_state_e;

  typedef enum logic [1:0] {
    MODE0 = 2'b00,
    MODE1 = 2'b01,
    MODE2 = 2'b10,
    MODE3 = 2'b11
  } spi_mode_e;

  // Data is sampled on SCK rising when idle-low with leading-edge phase, or idle-high with trailing-edge phase.
  function automatic logic sample_on_rise(input logic [1:0] mode);
    return ~(mode[1] ^ mode[0]);
  endfunction

endpackage

// File: rtl/spi_edge_sync.sv
// Multi-stage synchronizer for one asynchronous bit, with registered
// rise/fall pulses derived from the synchronized value.
module spi_edge_sync #(
  parameter int unsigned STAGES    = 2,
  parameter logic        RESET_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic sync,
  output logic rise,
  output logic fall
);

  logic [STAGES-1:0] chain;
  logic              prev;

  assign sync = chain[STAGES-1];

  // Pulses are registered, so they trail the synchronized transition by one clk.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      chain <= {STAGES{RESET_VAL}};
      prev  <= RESET_VAL;
      rise  <= 1'b0;
      fall  <= 1'b0;
    end else begin
      chain <= STAGES'({chain, din});
      prev  <= chain[STAGES-1];
      rise  <= chain[STAGES-1] & ~prev;
      fall  <= ~chain[STAGES-1] & prev;
    end
  end

endmodule

// File: rtl/spi_slave.sv
// SPI slave endpoint: oversampled SCK/CS/MOSI, LSB-first receive into rx_data
// with a one-cycle rx_valid strobe, fixed TX_DATA word returned on MISO.
module spi_slave
  import spi_pkg::*;
#(
  parameter int unsigned       WIDTH       = SPI_WIDTH,
  parameter logic [WIDTH-1:0]  TX_DATA     = WIDTH'(16'h0704),
  parameter int unsigned       SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             CKP,
  input  logic             CPH,
  input  logic             SCK,
  input  logic             CS,
  input  logic             MOSI,
  output logic             MISO,
  output logic [WIDTH-1:0] rx_data,
  output logic             rx_valid,
  output logic             busy
);

  localparam int unsigned     CNT_W    = $clog2(WIDTH + 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(WIDTH);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  logic sck_sync, sck_rise, sck_fall;
  logic cs_sync, cs_rise, cs_fall;
  logic mosi_sync, mosi_rise, mosi_fall;
  logic unused_sync;

  spi_edge_sync #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sck_sync (
    .clk  (clk),
    .rst  (rst),
    .din  (SCK),
    .sync (sck_sync),
    .rise (sck_rise),
    .fall (sck_fall)
  );

  spi_edge_sync #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b1)) u_cs_sync (
    .clk  (clk),
    .rst  (rst),
    .din  (CS),
    .sync (cs_sync),
    .rise (cs_rise),
    .fall (cs_fall)
  );

  spi_edge_sync #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_mosi_sync (
    .clk  (clk),
    .rst  (rst),
    .din  (MOSI),
    .sync (mosi_sync),
    .rise (mosi_rise),
    .fall (mosi_fall)
  );

  assign unused_sync = ^{sck_sync, cs_sync, mosi_rise, mosi_fall};

  spi_mode_e        mode;
  logic             sample_rise;
  logic             sample_edge;
  logic             shift_edge;
  logic [WIDTH-1:0] rx_shift_next;
  logic [WIDTH-1:0] tx_shifted;
  logic             tx_bit;

  spi_state_e       state;
  logic [CNT_W-1:0] bit_cnt;
  logic [CNT_W-1:0] tx_idx;
  logic [WIDTH-1:0] rx_shift;

  // Map the bus mode onto which synchronized SCK edge samples and which shifts.
  assign mode        = spi_mode_e'({CKP, CPH});
  assign sample_rise = sample_on_rise(mode);
  assign sample_edge = sample_rise ? sck_rise : sck_fall;
  assign shift_edge  = sample_rise ? sck_fall : sck_rise;

  // LSB-first: after WIDTH samples the first received bit lands in bit 0.
  assign rx_shift_next = {mosi_sync, rx_shift[WIDTH-1:1]};
  assign tx_shifted    = TX_DATA >> tx_idx;
  assign tx_bit        = tx_shifted[0];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= ST_IDLE;
      MISO     <= 1'b0;
      rx_data  <= '0;
      rx_valid <= 1'b0;
      busy     <= 1'b0;
      bit_cnt  <= '0;
      tx_idx   <= '0;
      rx_shift <= '0;
    end else begin
      rx_valid <= 1'b0;
      unique case (state)
        ST_IDLE: begin
          MISO     <= 1'b0;
          bit_cnt  <= '0;
          tx_idx   <= '0;
          rx_shift <= '0;
          // Leading-edge phase needs bit 0 on the wire before the first SCK edge.
          if (cs_fall) begin
            state <= ST_ACTIVE;
            busy  <= 1'b1;
            if (!CPH) begin
              MISO   <= TX_DATA[0];
              tx_idx <= CNT_ONE;
            end
          end
        end

        ST_ACTIVE: begin
          // CS release wins over a coincident final sample.
          if (cs_rise) begin
            state    <= ST_IDLE;
            busy     <= 1'b0;
            MISO     <= 1'b0;
            bit_cnt  <= '0;
            tx_idx   <= '0;
            rx_shift <= '0;
          end else if (sample_edge) begin
            rx_shift <= rx_shift_next;
            bit_cnt  <= bit_cnt + CNT_ONE;
            if (bit_cnt == CNT_LAST) begin
              rx_data  <= rx_shift_next;
              rx_valid <= 1'b1;
              MISO     <= 1'b0;
              state    <= ST_DONE;
            end
          end else if (shift_edge) begin
            if (tx_idx == CNT_MAX) begin
              MISO <= 1'b0;
            end else begin
              MISO   <= tx_bit;
              tx_idx <= tx_idx + CNT_ONE;
            end
          end
        end

        ST_DONE: begin
          MISO <= 1'b0;
          if (cs_rise) begin
            state <= ST_IDLE;
            busy  <= 1'b0;
          end
        end

        default: begin
          state <= ST_IDLE;
          busy  <= 1'b0;
          MISO  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_spi_slave.sv
// Self-checking bench for spi_slave: a bit-banged SPI master plus a
// word-level reference model of what the slave should receive and return.
module tb_spi_slave;

  localparam int unsigned WIDTH = 16;

  logic             clk = 1'b0;
  logic             rst;
  logic             CKP;
  logic             CPH;
  logic             SCK;
  logic             CS;
  logic             MOSI;
  logic             MISO;
  logic [WIDTH-1:0] rx_data;
  logic             rx_valid;
  logic             busy;

  spi_slave #(
    .WIDTH       (WIDTH),
    .TX_DATA     (16'h0704),
    .SYNC_STAGES (2)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .CKP      (CKP),
    .CPH      (CPH),
    .SCK      (SCK),
    .CS       (CS),
    .MOSI     (MOSI),
    .MISO     (MISO),
    .rx_data  (rx_data),
    .rx_valid (rx_valid),
    .busy     (busy)
  );

  always #5 clk = ~clk;

  int tests  = 0;
  int errors = 0;

  // Reference model state: words the slave should deliver, and rx_data expectation.
  logic [WIDTH-1:0] tx_word;
  logic [WIDTH-1:0] exp_last;
  logic [WIDTH-1:0] exp_q[$];
  logic [WIDTH-1:0] rx_q[$];
  int               consec = 0;
  logic             prev_valid = 1'b0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Record every strobe together with the word presented alongside it.
  always @(negedge clk) begin
    if (rx_valid === 1'b1) begin
      rx_q.push_back(rx_data);
      if (prev_valid === 1'b1) consec++;
    end
    prev_valid = rx_valid;
  end

  task automatic wait_clk(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Bit-banged master; cap holds the MISO bit taken at each sample edge.
  task automatic xfer(input logic [1:0] mode, input logic [WIDTH-1:0] word, input int ncyc,
                      input int half, input int gap, input bit keep_cs, output logic [31:0] cap);
    logic [31:0] mosi_bits;
    mosi_bits = $urandom;
    mosi_bits[WIDTH-1:0] = word;
    cap = '0;
    CKP = mode[1];
    CPH = mode[0];
    SCK = mode[1];
    CS  = 1'b1;
    wait_clk(gap);
    CS   = 1'b0;
    MOSI = mode[0] ? 1'b0 : mosi_bits[0];
    wait_clk(half);
    for (int i = 0; i < ncyc; i++) begin
      if (!mode[0]) begin
        cap[i] = MISO;
        SCK = ~mode[1];
        wait_clk(half);
        SCK  = mode[1];
        MOSI = mosi_bits[i+1];
        wait_clk(half);
      end else begin
        SCK  = ~mode[1];
        MOSI = mosi_bits[i];
        wait_clk(half);
        cap[i] = MISO;
        SCK = mode[1];
        wait_clk(half);
      end
    end
    if (!keep_cs) CS = 1'b1;
  endtask

  // Expected master capture: the fixed word LSB first, zeros past WIDTH bits.
  function automatic logic [31:0] exp_capture(input int ncyc);
    logic [31:0] e;
    e = '0;
    for (int i = 0; i < ncyc; i++) e[i] = (i < int'(WIDTH)) ? tx_word[i] : 1'b0;
    return e;
  endfunction

  task automatic model_xfer(input logic [WIDTH-1:0] word, input int ncyc);
    if (ncyc >= int'(WIDTH)) begin
      exp_q.push_back(word);
      exp_last = word;
    end
  endtask

  task automatic drain(input string tag);
    check({tag, "_count"}, 32'(rx_q.size()), 32'(exp_q.size()));
    for (int i = 0; i < exp_q.size() && i < rx_q.size(); i++)
      check({tag, "_word"}, 32'(rx_q[i]), 32'(exp_q[i]));
    check({tag, "_rx_data"}, 32'(rx_data), 32'(exp_last));
    check({tag, "_busy"}, 32'(busy), 32'(0));
    check({tag, "_miso_idle"}, 32'(MISO), 32'(0));
    rx_q.delete();
    exp_q.delete();
  endtask

  task automatic full(input string tag, input logic [1:0] mode, input logic [WIDTH-1:0] word,
                      input int ncyc, input int half);
    logic [31:0] cap;
    xfer(mode, word, ncyc, half, 8, 1'b0, cap);
    model_xfer(word, ncyc);
    check({tag, "_miso_word"}, cap, exp_capture(ncyc));
    wait_clk(6);
    drain(tag);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: time limit reached, tests=%0d", tests);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] cap;
    logic [31:0] cap2;
    logic [1:0]  mode;
    logic [WIDTH-1:0] w;
    int          n;
    int          half;

    tx_word  = 16'h0704;
    exp_last = '0;
    rst  = 1'b1;
    CKP  = 1'b0;
    CPH  = 1'b0;
    SCK  = 1'b0;
    CS   = 1'b1;
    MOSI = 1'b0;
    wait_clk(3);
    check("reset_miso", 32'(MISO), 32'(0));
    check("reset_rx_data", 32'(rx_data), 32'(0));
    check("reset_rx_valid", 32'(rx_valid), 32'(0));
    check("reset_busy", 32'(busy), 32'(0));
    rst = 1'b0;
    wait_clk(4);
    check("post_reset_busy", 32'(busy), 32'(0));

    // Same exchange in all four modes.
    for (int m = 0; m < 4; m++) full($sformatf("mode%0d", m), 2'(m), 16'h0407, 16, 4);

    // Abort after 7 SCK cycles, then a full transfer.
    xfer(2'b00, 16'hBEEF, 7, 4, 8, 1'b1, cap);
    check("abort_miso_word", cap, exp_capture(7));
    CS = 1'b1;
    wait_clk(4);
    check("abort_busy", 32'(busy), 32'(0));
    wait_clk(2);
    drain("abort");
    full("after_abort", 2'b00, 16'hA5C3, 16, 4);

    // Extra SCK cycles inside one CS window.
    full("extra_m0", 2'b00, 16'h1234, 18, 4);
    full("extra_m3", 2'b11, 16'hFEDC, 18, 4);

    // Reset after bit 9; outputs must clear immediately.
    xfer(2'b01, 16'h5A5A, 9, 4, 8, 1'b1, cap);
    rst = 1'b1;
    #1;
    check("midrst_miso", 32'(MISO), 32'(0));
    check("midrst_rx_data", 32'(rx_data), 32'(0));
    check("midrst_rx_valid", 32'(rx_valid), 32'(0));
    check("midrst_busy", 32'(busy), 32'(0));
    exp_last = '0;
    wait_clk(1);
    rst = 1'b0;
    CS  = 1'b1;
    wait_clk(8);
    drain("midrst_idle");
    full("after_reset", 2'b01, 16'h3C96, 16, 4);

    // Back-to-back with only 4 clk of CS high between words.
    xfer(2'b10, 16'h1357, 16, 4, 8, 1'b0, cap);
    model_xfer(16'h1357, 16);
    xfer(2'b10, 16'h2468, 16, 4, 4, 1'b0, cap2);
    model_xfer(16'h2468, 16);
    check("b2b_miso_word0", cap, exp_capture(16));
    check("b2b_miso_word1", cap2, exp_capture(16));
    wait_clk(6);
    drain("b2b");

    // Randomized traffic: mode, word, SCK speed, length including aborts.
    for (int k = 0; k < 12; k++) begin
      mode = 2'($urandom_range(0, 3));
      w    = 16'($urandom);
      half = $urandom_range(4, 6);
      n    = ($urandom_range(0, 3) == 0) ? $urandom_range(3, 15) : $urandom_range(16, 18);
      full($sformatf("rand%0d", k), mode, w, n, half);
    end

    check("no_consecutive_valid", 32'(consec), 32'(0));
    $display("[TB] %0d tests run, %0d failed", tests, errors);
    $finish;
  end

endmodule
